// File: rtl/memory_access_stage_pkg.sv
// Shared encodings for the memory access stage: opcodes, access-size codes and FSM states.
// Also holds the alignment rule so capture logic and any checker agree on it.
package memory_access_stage_pkg;

    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } mem_state_e;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic r_mis;
        case (funct3[1:0])
            2'b01:   r_mis = offset[0];
            2'b10:   r_mis = |offset;
            default: r_mis = 1'b0;
        endcase
        return r_mis;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/halfword lane of a load word and sign- or zero-extends it.
module mem_load_ext
    import memory_access_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3Byte:  o_data = {{24{w_byte[7]}}, w_byte};
            F3ByteU: o_data = {24'h000000, w_byte};
            F3Half:  o_data = {{16{w_half[15]}}, w_half};
            F3HalfU: o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline M stage: holds one instruction, runs a req/gnt/rvalid data-memory transaction for
// aligned loads and stores, and hands the result to write-back with valid/allow-in handshaking.
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        e_to_m_valid,
    output logic        m_allow_in,
    input  logic [6:0]  E_opcode,
    input  logic [4:0]  E_rd,
    input  logic [31:0] E_valE,
    input  logic [31:0] E_valB,
    input  logic [31:0] E_default_pc,
    input  logic [31:0] E_cur_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_pred_pc,
    input  logic        E_commit,

    output logic        m_valid,
    output logic [6:0]  M_opcode,
    output logic [4:0]  M_rd,
    output logic [31:0] M_valE,
    output logic [31:0] M_default_pc,
    output logic [31:0] M_cur_pc,
    output logic [31:0] M_instr,
    output logic        M_commit,
    output logic [31:0] M_pred_pc,
    output logic [31:0] m_valM,
    output logic        m_misalign,

    output logic        m_to_w_valid,
    input  logic        w_allow_in,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    mem_state_e  r_state;
    logic        r_valid;
    logic [31:0] r_valM;
    logic        r_misalign;
    logic [31:0] r_valB;

    logic        w_e_is_mem;
    logic        w_e_misalign;
    logic        w_e_mem_go;
    logic        w_m_ready_go;
    logic        w_capture;
    logic        w_m_is_load;
    logic        w_m_is_store;
    logic [2:0]  w_m_funct3;
    logic [1:0]  w_m_offset;
    logic [31:0] w_load_data;

    // Alignment is decided from the incoming payload so the capture edge picks REQ or IDLE
    assign w_e_is_mem   = (E_opcode == OpcLoad) || (E_opcode == OpcStore);
    assign w_e_misalign = w_e_is_mem && is_misaligned(E_instr[14:12], E_valE[1:0]);
    assign w_e_mem_go   = w_e_is_mem && !w_e_misalign;

    assign w_m_ready_go = (r_state == StDone) || ((r_state == StIdle) && r_valid);
    assign m_allow_in   = !r_valid || (w_m_ready_go && w_allow_in);
    assign m_to_w_valid = r_valid && w_m_ready_go;
    assign w_capture    = m_allow_in && e_to_m_valid;

    assign w_m_is_load  = (M_opcode == OpcLoad);
    assign w_m_is_store = (M_opcode == OpcStore);
    assign w_m_funct3   = M_instr[14:12];
    assign w_m_offset   = M_valE[1:0];

    assign m_valid      = r_valid;
    assign m_valM       = r_valM;
    assign m_misalign   = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (m_allow_in) begin
            r_valid <= e_to_m_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_opcode     <= 7'd0;
            M_rd         <= 5'd0;
            M_valE       <= 32'd0;
            M_default_pc <= 32'd0;
            M_cur_pc     <= 32'd0;
            M_instr      <= 32'd0;
            M_commit     <= 1'b0;
            M_pred_pc    <= 32'd0;
            r_valB       <= 32'd0;
        end else if (w_capture) begin
            M_opcode     <= E_opcode;
            M_rd         <= E_rd;
            M_valE       <= E_valE;
            M_default_pc <= E_default_pc;
            M_cur_pc     <= E_cur_pc;
            M_instr      <= E_instr;
            M_commit     <= E_commit;
            M_pred_pc    <= E_pred_pc;
            r_valB       <= E_valB;
        end
    end

    // m_allow_in is only ever high in IDLE or DONE, so it never races the REQ/WAIT arcs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_valM     <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                StReq: begin
                    if (dmem_gnt) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (dmem_rvalid) begin
                        r_state <= StDone;
                        if (w_m_is_load) begin
                            r_valM <= w_load_data;
                        end
                    end
                end
                default: ;
            endcase
            if (m_allow_in) begin
                r_state    <= (w_capture && w_e_mem_go) ? StReq : StIdle;
                r_misalign <= w_capture && w_e_misalign;
                if (w_capture) begin
                    r_valM <= 32'd0;
                end
            end
        end
    end

    assign dmem_req  = (r_state == StReq);
    assign dmem_we   = dmem_req && w_m_is_store;
    assign dmem_addr = {M_valE[31:2], 2'b00};

    always_comb begin
        dmem_wdata = r_valB;
        dmem_wstrb = 4'b0000;
        if (w_m_is_store) begin
            case (w_m_funct3[1:0])
                2'b00: begin
                    dmem_wdata = {4{r_valB[7:0]}};
                    dmem_wstrb = 4'b0001 << w_m_offset;
                end
                2'b01: begin
                    dmem_wdata = {2{r_valB[15:0]}};
                    dmem_wstrb = 4'b0011 << w_m_offset;
                end
                default: begin
                    dmem_wdata = r_valB;
                    dmem_wstrb = 4'b1111;
                end
            endcase
        end
    end

    mem_load_ext u_load_ext (
        .i_funct3 (w_m_funct3),
        .i_offset (w_m_offset),
        .i_rdata  (dmem_rdata),
        .o_data   (w_load_data)
    );

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, misalignment, back-pressure and reset.
module tb_memory_access_stage;

    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_to_m_valid;
    logic        m_allow_in;
    logic [6:0]  E_opcode;
    logic [4:0]  E_rd;
    logic [31:0] E_valE, E_valB, E_default_pc, E_cur_pc, E_instr, E_pred_pc;
    logic        E_commit;
    logic        m_valid;
    logic [6:0]  M_opcode;
    logic [4:0]  M_rd;
    logic [31:0] M_valE, M_default_pc, M_cur_pc, M_instr, M_pred_pc;
    logic        M_commit;
    logic [31:0] m_valM;
    logic        m_misalign;
    logic        m_to_w_valid;
    logic        w_allow_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int n_req_hs = 0;
    int n_wb_hs  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (dmem_req && dmem_gnt) n_req_hs <= n_req_hs + 1;
            if (m_to_w_valid && w_allow_in) n_wb_hs <= n_wb_hs + 1;
        end
    end

    memory_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .e_to_m_valid (e_to_m_valid),
        .m_allow_in   (m_allow_in),
        .E_opcode     (E_opcode),
        .E_rd         (E_rd),
        .E_valE       (E_valE),
        .E_valB       (E_valB),
        .E_default_pc (E_default_pc),
        .E_cur_pc     (E_cur_pc),
        .E_instr      (E_instr),
        .E_pred_pc    (E_pred_pc),
        .E_commit     (E_commit),
        .m_valid      (m_valid),
        .M_opcode     (M_opcode),
        .M_rd         (M_rd),
        .M_valE       (M_valE),
        .M_default_pc (M_default_pc),
        .M_cur_pc     (M_cur_pc),
        .M_instr      (M_instr),
        .M_commit     (M_commit),
        .M_pred_pc    (M_pred_pc),
        .m_valM       (m_valM),
        .m_misalign   (m_misalign),
        .m_to_w_valid (m_to_w_valid),
        .w_allow_in   (w_allow_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        e_to_m_valid = 1'b1;
        E_opcode     = opc;
        E_instr      = {17'h0, f3, 5'd7, opc};
        E_valE       = addr;
        E_valB       = data;
        E_cur_pc     = addr + 32'h1000;
        E_pred_pc    = addr + 32'h1004;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive(OPC_LD, f3, addr, 32'h0);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = rdata; w_allow_in = 1'b1;
        #1 chk({tag, "_allow"}, m_allow_in, 1);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_we"}, dmem_we, 0);
        chk({tag, "_m2w_n1"}, m_to_w_valid, 0);
        wait_edge(); #1;
        chk({tag, "_m2w_n2"}, m_to_w_valid, 0);
        wait_edge(); #1;
        chk({tag, "_m2w_n3"}, m_to_w_valid, 1);
        chk({tag, "_valM"}, m_valM, exp);
        wait_edge(); #1;
        chk({tag, "_drain"}, m_valid, 0);
    endtask

    int base_req, base_wb;

    initial begin
        rst_n = 1'b0; e_to_m_valid = 1'b0; w_allow_in = 1'b1;
        E_opcode = '0; E_rd = 5'd7; E_valE = '0; E_valB = '0; E_default_pc = 32'h44;
        E_cur_pc = '0; E_instr = '0; E_pred_pc = '0; E_commit = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset is asynchronous: check before the first clock edge
        #3;
        chk("rst_valid", m_valid, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_valM", m_valM, 0);
        chk("rst_mis", m_misalign, 0);
        chk("rst_Mop", M_opcode, 0);
        chk("rst_allow", m_allow_in, 1);
        wait_edge();
        rst_n = 1'b1;
        wait_edge();

        do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("lw_Mcur", M_cur_pc, 32'h1100);
        chk("lw_Mrd", M_rd, 5'd7);
        do_load("lb", 3'b000, 32'h103, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FFFFFF, 32'h00000080);
        do_load("lh", 3'b001, 32'h102, 32'h80FFFFFF, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h100, 32'h1234ABCD, 32'h0000ABCD);

        // SH to 0x202
        drive(OPC_ST, 3'b001, 32'h202, 32'h00001234);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk("sh_req", dmem_req, 1);
        chk("sh_we", dmem_we, 1);
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'h12341234);
        chk("sh_addr", dmem_addr, 32'h200);
        wait_edge(); wait_edge(); #1;
        chk("sh_m2w", m_to_w_valid, 1);
        chk("sh_valM", m_valM, 0);
        wait_edge();

        // SB to 0x201
        drive(OPC_ST, 3'b000, 32'h201, 32'hFFFFFFAB);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk("sb_wstrb", dmem_wstrb, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        wait_edge(); wait_edge(); wait_edge();

        // Misaligned LW: passes straight through
        drive(OPC_LD, 3'b010, 32'h101, 32'h0);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk("mis_req", dmem_req, 0);
        chk("mis_flag", m_misalign, 1);
        chk("mis_valM", m_valM, 0);
        chk("mis_m2w", m_to_w_valid, 1);
        wait_edge(); #1;
        chk("mis_drain", m_valid, 0);
        chk("mis_clear", m_misalign, 0);

        // Non-memory op
        drive(OPC_ALU, 3'b000, 32'h0000_0042, 32'h0);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk("alu_m2w", m_to_w_valid, 1);
        chk("alu_req", dmem_req, 0);
        chk("alu_Mval", M_valE, 32'h42);
        wait_edge();

        // Delayed grant and write-back stall
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; w_allow_in = 1'b1;
        base_req = n_req_hs; base_wb = n_wb_hs;
        drive(OPC_LD, 3'b010, 32'h300, 32'h0);
        wait_edge();
        drive(OPC_ALU, 3'b000, 32'h999, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req", dmem_req, 1);
            chk("bp_addr", dmem_addr, 32'h300);
            chk("bp_allow", m_allow_in, 0);
            chk("bp_hold", M_valE, 32'h300);
            wait_edge();
        end
        dmem_gnt = 1'b1;
        wait_edge();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; w_allow_in = 1'b0;
        #1;
        chk("bp_wait_req", dmem_req, 0);
        chk("bp_wait_allow", m_allow_in, 0);
        wait_edge();
        dmem_rdata = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_done_m2w", m_to_w_valid, 1);
            chk("bp_done_allow", m_allow_in, 0);
            chk("bp_done_valM", m_valM, 32'hCAFEF00D);
            chk("bp_done_Mval", M_valE, 32'h300);
            chk("bp_done_req", dmem_req, 0);
            wait_edge();
        end
        dmem_rvalid = 1'b0; w_allow_in = 1'b1;
        #1;
        chk("bp_release_allow", m_allow_in, 1);
        wait_edge();
        e_to_m_valid = 1'b0;
        #1;
        chk("bp_next_op", M_opcode, OPC_ALU);
        chk("bp_next_val", M_valE, 32'h999);
        chk("bp_next_valM", m_valM, 0);
        chk("bp_req_count", n_req_hs - base_req, 1);
        chk("bp_wb_count", n_wb_hs - base_wb, 1);
        wait_edge();

        // Reset during WAIT, late rvalid afterwards
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        drive(OPC_LD, 3'b010, 32'h400, 32'h0);
        wait_edge();
        e_to_m_valid = 1'b0;
        wait_edge();
        #1;
        chk("rw_wait_req", dmem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("rw_valid", m_valid, 0);
        chk("rw_Mval", M_valE, 0);
        chk("rw_Mop", M_opcode, 0);
        chk("rw_m2w", m_to_w_valid, 0);
        wait_edge();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h00000055;
        wait_edge(); #1;
        chk("rw_late_valM", m_valM, 0);
        chk("rw_late_valid", m_valid, 0);
        chk("rw_late_req", dmem_req, 0);
        dmem_rvalid = 1'b0;
        wait_edge(); #1;
        chk("rw_late_valM2", m_valM, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 e_to_m_valid  in  1  execute stage presents a valid instruction.
REQ-005 m_allow_in  out  1  stage can accept a new instruction this cycle.
REQ-006 E_opcode[6:0], E_rd[4:0], E_valE[31:0] (ALU result/address), E_valB[31:0] (store data), E_default_pc, E_cur_pc, E_instr, E_pred_pc[31:0], E_commit[0]  in  upstream payload.
REQ-007 m_valid  out  1  M register holds a live instruction.
REQ-008 M_opcode, M_rd, M_valE, M_default_pc, M_cur_pc, M_instr, M_commit, M_pred_pc  out  registered copies of the E_* fields, same widths.
REQ-009 m_valM  out  32  load result, aligned and extended; 0 for non-loads.
REQ-010 m_misalign  out  1  current instruction is a misaligned load/store.
REQ-011 m_to_w_valid  out  1  result valid to write-back.
REQ-012 w_allow_in  in  1  write-back can accept.
REQ-013 dmem_req, dmem_we  out  1  request strobe; write enable.
REQ-014 dmem_addr[31:0] (bits 1:0 forced 0), dmem_wdata[31:0], dmem_wstrb[3:0]  out  request payload.
REQ-015 dmem_gnt, dmem_rvalid  in  1  request accepted; response (load data or store ack).
REQ-016 dmem_rdata  in  32  load word.

Function
REQ-017 m_allow_in SHALL equal ~m_valid | (m_ready_go & w_allow_in); m_to_w_valid SHALL equal m_valid & m_ready_go.
REQ-018 On m_allow_in & e_to_m_valid, M_* SHALL capture E_*; m_valid SHALL load e_to_m_valid whenever m_allow_in.
REQ-019 Memory ops: opcode 0000011 (load), 0100011 (store); funct3 = M_instr[14:12].
REQ-020 FSM states IDLE, REQ, WAIT, DONE; capture of an aligned load/store SHALL enter REQ, any other capture IDLE.
REQ-021 REQ: dmem_req=1 with stable payload until dmem_gnt; gnt -> WAIT.
REQ-022 WAIT: dmem_rvalid -> DONE, latching m_valM (loads) in the same edge.
REQ-023 DONE: when w_allow_in, next state per REQ-020 for a newly captured instruction, else IDLE.
REQ-024 m_ready_go SHALL be 1 in DONE, or in IDLE with m_valid (non-memory or misaligned).
REQ-025 Minimum load latency: capture edge N, gnt in cycle N+1, rvalid cycle N+2, m_to_w_valid cycle N+3.
REQ-026 Stores: wstrb SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; wdata = store data replicated to byte/halfword lanes.
REQ-027 Loads: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW whole word.
REQ-028 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no dmem request, m_misalign=1, m_valM=0, passes through as non-memory.
REQ-029 dmem_rvalid outside WAIT and dmem_gnt outside REQ SHALL be ignored.
REQ-030 Back-pressure: while DONE and ~w_allow_in, m_valM and M_* SHALL hold.

Reset
REQ-031 rst_n low SHALL force m_valid=0, state IDLE, dmem_req=0, dmem_we=0, m_valM=0, m_misalign=0, all M_* = 0, immediately and regardless of clk.
REQ-032 Reset mid-transaction SHALL abandon it; a late rvalid after release SHALL be discarded.

Structure
REQ-033 Opcode constants, funct3 codes and the FSM state encoding SHALL live in the shared package/define file.
REQ-034 Load lane select/extension SHALL be one combinational sub-module, mem_load_ext.

Verification
REQ-035 LW addr 0x100, rdata 0xDEADBEEF, gnt/rvalid immediate -> m_valM 0xDEADBEEF, m_to_w_valid at capture+3.
REQ-036 LB addr 0x103, rdata 0x80FFFFFF -> m_valM 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, data 0x1234 -> wstrb 1100, wdata 0x12341234, we=1.
REQ-038 LW addr 0x101 -> no dmem_req, m_misalign=1, m_valM=0, m_to_w_valid at capture+1.
REQ-039 gnt delayed 3 cycles, w_allow_in low 2 cycles in DONE -> payload stable, no duplicate transfer, m_allow_in=0 throughout.
REQ-040 rst_n low during WAIT, rvalid arrives after release -> m_valid=0, m_valM stays 0.
